// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment encoder/reader pair: segment patterns,
// digit-select codes, reader FSM states and the BCD-pair to binary helper.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] SEL_BLANK   = 2'b00;
    localparam logic [1:0] SEL_RIGHT   = 2'b01;
    localparam logic [1:0] SEL_LEFT    = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        WAIT_LEFT  = 2'd0,
        WAIT_RIGHT = 2'd1,
        EMIT       = 2'd2
    } readerState_e;

    // tens*10 + units as shift-add; the result never exceeds 99
    function automatic logic [6:0] bcdPairToBinary(input logic [3:0] tens,
                                                   input logic [3:0] units);
        logic [6:0] t;
        t = {3'b000, tens};
        return (t << 3) + (t << 1) + {3'b000, units};
    endfunction

endpackage

// File: rtl/seven_segment_digit_decoder.sv
// Combinational seven-segment to BCD decode of a single digit. An all-off
// pattern is accepted as 0 only on the tens digit (leading-zero blanking).
module seven_segment_digit_decoder
    import seven_segment_pkg::*;
(
    input  logic [6:0] segIn,
    input  logic       isLeft,
    output logic [3:0] bcd,
    output logic       valid
);

    always_comb begin
        bcd   = 4'd0;
        valid = 1'b1;
        case (segIn)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: valid = isLeft;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Recovers a two-digit decimal value from a multiplexed seven-segment bus:
// debounce each digit over a stability window, decode, then assemble tens/units.
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] segIn,
    input  logic [1:0] digitSel,
    output logic [6:0] decimalNumber,
    output logic [3:0] leftDigit,
    output logic [3:0] rightDigit,
    output logic       numberValid,
    output logic       decodeError
);

    logic [8:0]   incoming;
    logic [8:0]   sampleReg;
    logic [3:0]   stableCount;
    logic         sampleRepeat;
    logic         captureNow;
    logic [1:0]   captureSel;
    logic [3:0]   digitBcd;
    logic         digitValid;
    logic [3:0]   tensHold;
    logic         loadTens;
    logic         loadOutputs;
    logic         flagError;
    readerState_e state;
    readerState_e nextState;

    assign incoming   = {digitSel, segIn};
    assign captureSel = sampleReg[8:7];

    // A zero count (only after reset) makes the first sample count as a change.
    // The capture fires on the edge where the count climbs to STABLE_CYCLES,
    // at which point the sample register already holds that same value.
    assign sampleRepeat = (stableCount != 4'd0) && (incoming == sampleReg);
    assign captureNow   = sampleRepeat && (stableCount == 4'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sampleReg   <= 9'd0;
            stableCount <= 4'd0;
        end else begin
            sampleReg <= incoming;
            if (!sampleRepeat) begin
                stableCount <= 4'd1;
            end else if (stableCount != 4'(STABLE_CYCLES)) begin
                stableCount <= stableCount + 4'd1;
            end
        end
    end

    seven_segment_digit_decoder digitDecoder (
        .segIn  (sampleReg[6:0]),
        .isLeft (captureSel == SEL_LEFT),
        .bcd    (digitBcd),
        .valid  (digitValid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LEFT;
        end else begin
            state <= nextState;
        end
    end

    // Blank captures are ignored everywhere; EMIT drops any capture outright.
    always_comb begin
        nextState   = state;
        loadTens    = 1'b0;
        loadOutputs = 1'b0;
        flagError   = 1'b0;
        case (state)
            WAIT_LEFT, WAIT_RIGHT: begin
                if (captureNow && captureSel != SEL_BLANK) begin
                    if (captureSel == SEL_ILLEGAL || !digitValid) begin
                        flagError = 1'b1;
                        nextState = WAIT_LEFT;
                    end else if (captureSel == SEL_LEFT) begin
                        loadTens  = 1'b1;
                        nextState = WAIT_RIGHT;
                    end else if (state == WAIT_RIGHT) begin
                        loadOutputs = 1'b1;
                        nextState   = EMIT;
                    end
                end
            end
            EMIT:    nextState = WAIT_LEFT;
            default: nextState = WAIT_LEFT;
        endcase
    end

    // Outputs load on the edge entering EMIT so they are valid alongside numberValid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tensHold      <= 4'd0;
            leftDigit     <= 4'd0;
            rightDigit    <= 4'd0;
            decimalNumber <= 7'd0;
            decodeError   <= 1'b0;
        end else begin
            decodeError <= flagError;
            if (loadTens) begin
                tensHold <= digitBcd;
            end
            if (loadOutputs) begin
                leftDigit     <= tensHold;
                rightDigit    <= digitBcd;
                decimalNumber <= bcdPairToBinary(tensHold, digitBcd);
            end
        end
    end

    assign numberValid = (state == EMIT);

endmodule
